// File: rtl/cvt_sample_unpack_if.sv
// Converter-FIFO read port and unpacked sample stream, grouped for cvt_sample_unpack.
// master = unpacker side, slave = FIFO/downstream side.
interface cvt_sample_unpack_if #(
    parameter int LANE_W = 16
);
    logic                  cvt_data_queue_empty;
    logic                  cvt_data_queue_almost_empty;
    logic                  cvt_data_valid;
    logic [3*LANE_W-1:0]   cvt_data;
    logic                  rd_enable;
    logic                  sample_valid;
    logic                  sample_ready;
    logic [LANE_W-1:0]     sample_data;
    logic                  sample_last;

    modport master (
        input  cvt_data_queue_empty, cvt_data_queue_almost_empty, cvt_data_valid, cvt_data,
        input  sample_ready,
        output rd_enable, sample_valid, sample_data, sample_last
    );

    modport slave (
        output cvt_data_queue_empty, cvt_data_queue_almost_empty, cvt_data_valid, cvt_data,
        output sample_ready,
        input  rd_enable, sample_valid, sample_data, sample_last
    );
endinterface

// File: rtl/cvt_sample_unpack.sv
// Pops 3-lane words from the converter FIFO and streams them out one lane per
// handshake (high lane first), tracking frame length and flagging the last sample.
module cvt_sample_unpack #(
    parameter int LANE_W    = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic                 clk_rd,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic [31:0]          frame_len,
    cvt_sample_unpack_if.master  bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 stray_valid
);
    localparam int WORD_W = 3 * LANE_W;
    localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
    localparam int CNT_W1 = CNT_W + 1;
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W1-1:0] DEPTH    = CNT_W1'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_next;
    logic [WORD_W-1:0]   word_buf [BUF_DEPTH];
    logic [PTR_W-1:0]    head, tail;
    logic [CNT_W-1:0]    count, outs;
    logic [31:0]         samp_left, words_left, words_init;
    logic [1:0]          lane;
    logic                rd_en;
    logic                start_ok, room, issue, valid_i, handshake, pop, wr;
    logic [WORD_W-1:0]   head_word;
    logic [LANE_W-1:0]   lane_data;

    // A new frame may also be accepted on the frame_done cycle.
    assign start_ok   = frame_start && (state != RUN);
    assign words_init = 32'(({1'b0, frame_len} + 33'd2) / 33'd3);
    // rd_enable is registered, so the FIFO's empty flag does not yet reflect a pop
    // issued this cycle; skipping back-to-back requests avoids reading past the end.
    assign room       = (({1'b0, outs} + {1'b0, count}) < DEPTH) && !rd_en
                        && !bus.cvt_data_queue_empty;
    assign valid_i    = (state == RUN) && (count != '0);
    assign handshake  = valid_i && bus.sample_ready;
    assign pop        = handshake && ((lane == 2'd2) || (samp_left == 32'd1));
    assign wr         = bus.cvt_data_valid && (outs != '0);
    assign head_word  = word_buf[head];

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            RUN: begin
                issue = room && (words_left != 32'd0);
                if (handshake && (samp_left == 32'd1))
                    state_next = DONE;
            end
            default: begin
                if (start_ok) begin
                    if (frame_len == 32'd0) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                        issue      = room;
                    end
                end else if (state == DONE) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        lane_data = head_word[LANE_W-1:0];
        case (lane)
            2'd0:    lane_data = head_word[WORD_W-1 -: LANE_W];
            2'd1:    lane_data = head_word[2*LANE_W-1 -: LANE_W];
            default: lane_data = head_word[LANE_W-1:0];
        endcase
    end

    assign bus.rd_enable    = rd_en;
    assign bus.sample_valid = valid_i;
    assign bus.sample_data  = valid_i ? lane_data : '0;
    assign bus.sample_last  = valid_i && (samp_left == 32'd1);
    assign busy             = (state == RUN);
    assign frame_done       = (state == DONE);

    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_en       <= 1'b0;
            outs        <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            samp_left   <= '0;
            words_left  <= '0;
            lane        <= '0;
            stray_valid <= 1'b0;
        end else begin
            state <= state_next;
            rd_en <= issue;

            case ({issue, wr})
                2'b10:   outs <= outs + CNT_W'(1);
                2'b01:   outs <= outs - CNT_W'(1);
                default: outs <= outs;
            endcase

            case ({wr, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (wr)  tail <= (tail == PTR_LAST) ? '0 : tail + 1'b1;
            if (pop) head <= (head == PTR_LAST) ? '0 : head + 1'b1;

            if (start_ok)
                words_left <= words_init - {31'd0, issue};
            else if (issue)
                words_left <= words_left - 32'd1;

            if (start_ok)
                samp_left <= frame_len;
            else if (handshake)
                samp_left <= samp_left - 32'd1;

            if ((state == DONE) || start_ok)
                lane <= 2'd0;
            else if (handshake)
                lane <= pop ? 2'd0 : lane + 2'd1;

            if (bus.cvt_data_valid && (outs == '0))
                stray_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk_rd) begin
        if (wr)
            word_buf[tail] <= bus.cvt_data;
    end
endmodule

// File: tb/tb_cvt_sample_unpack.sv
// Directed bench for cvt_sample_unpack with a behavioural converter FIFO and
// a stream monitor; checks are immediate assertions in one linear sequence.
module tb_cvt_sample_unpack;
    logic        clk_rd = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [31:0] frame_len;
    logic        busy, frame_done, stray_valid;

    always #5 clk_rd = ~clk_rd;

    cvt_sample_unpack_if #(.LANE_W(16)) bus ();

    cvt_sample_unpack #(.LANE_W(16), .BUF_DEPTH(2)) dut (
        .clk_rd      (clk_rd),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .frame_len   (frame_len),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .stray_valid (stray_valid)
    );

    // FIFO model: data returns one cycle after rd_enable
    logic [47:0] q[$];
    logic        fifo_valid = 1'b0;
    logic        inj_valid  = 1'b0;
    logic        hold_empty = 1'b0;
    logic [47:0] fifo_data  = '0;
    int          underflow  = 0;

    assign bus.cvt_data_valid = fifo_valid | inj_valid;
    assign bus.cvt_data       = fifo_data;

    always @(posedge clk_rd) begin
        if (bus.rd_enable && q.size() > 0) begin
            fifo_data  <= q.pop_front();
            fifo_valid <= 1'b1;
        end else begin
            fifo_valid <= 1'b0;
            if (bus.rd_enable) underflow++;
        end
    end

    always @(negedge clk_rd) begin
        bus.cvt_data_queue_empty        = hold_empty || (q.size() == 0);
        bus.cvt_data_queue_almost_empty = (q.size() <= 1);
    end

    // Stream monitor
    int          cyc = 0;
    logic [15:0] got[$];
    int          n_rd, n_done, n_last, gap_rd, stall_bad, first_cyc, last_cyc, done_cyc;
    logic [15:0] last_val, prev_data;
    logic        prev_stall, prev_last, hold_d;

    always @(posedge clk_rd) cyc <= cyc + 1;

    always @(negedge clk_rd) begin
        if (bus.rd_enable) n_rd++;
        if (bus.rd_enable && hold_empty && hold_d) gap_rd++;
        hold_d = hold_empty;
        if (frame_done) begin n_done++; done_cyc = cyc; end
        if (prev_stall && (!bus.sample_valid || bus.sample_data !== prev_data
                           || bus.sample_last !== prev_last))
            stall_bad++;
        prev_stall = bus.sample_valid && !bus.sample_ready;
        prev_data  = bus.sample_data;
        prev_last  = bus.sample_last;
        if (bus.sample_valid && bus.sample_ready) begin
            if (got.size() == 0) first_cyc = cyc;
            got.push_back(bus.sample_data);
            if (bus.sample_last) begin n_last++; last_val = bus.sample_data; last_cyc = cyc; end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] mkw(input logic [15:0] b);
        return {b, 16'(b + 16'd1), 16'(b + 16'd2)};
    endfunction

    task automatic clear_mon();
        got.delete();
        n_rd = 0; n_done = 0; n_last = 0; gap_rd = 0; stall_bad = 0;
        first_cyc = -1; last_cyc = -1; done_cyc = -1; last_val = '0;
        prev_stall = 1'b0; hold_d = 1'b0;
    endtask

    task automatic start(input logic [31:0] len);
        frame_len   = len;
        frame_start = 1'b1;
        @(posedge clk_rd); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit toggle, input int gap_at);
        int  d0;
        bit  ok;
        d0 = n_done;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus.sample_ready = toggle ? ~bus.sample_ready : 1'b1;
            hold_empty = (gap_at >= 0) && (i >= gap_at) && (i < gap_at + 5);
            @(posedge clk_rd); #1;
            if (n_done != d0) begin ok = 1'b1; break; end
        end
        hold_empty       = 1'b0;
        bus.sample_ready = 1'b1;
        check({tag, "_done_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic check_samples(input string tag, input logic [15:0] base, input int n);
        check({tag, "_count"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            check({tag, "_data"}, 64'(got[i]), 64'(base + 16'(i)));
        check({tag, "_nlast"}, 64'(n_last), 64'd1);
        check({tag, "_lastval"}, 64'(last_val), 64'(base + 16'(n - 1)));
        check({tag, "_done_lat"}, 64'(done_cyc - last_cyc), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        frame_start      = 1'b0;
        frame_len        = '0;
        bus.sample_ready = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk_rd);
        #1;
        check("rst_rd_enable",    64'(bus.rd_enable),    64'd0);
        check("rst_sample_valid", 64'(bus.sample_valid), 64'd0);
        check("rst_sample_data",  64'(bus.sample_data),  64'd0);
        check("rst_sample_last",  64'(bus.sample_last),  64'd0);
        check("rst_busy",         64'(busy),             64'd0);
        check("rst_frame_done",   64'(frame_done),       64'd0);
        check("rst_stray",        64'(stray_valid),      64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_rd);
        #1;

        // Six samples from two words, full throughput
        q.push_back(mkw(16'h0001));
        q.push_back(mkw(16'h0004));
        @(posedge clk_rd); #1;
        clear_mon();
        start(32'd6);
        check("f6_busy_t1", 64'(busy), 64'd1);
        check("f6_rd_t1",   64'(bus.rd_enable), 64'd1);
        wait_done("f6", 1'b0, -1);
        check_samples("f6", 16'h0001, 6);
        check("f6_consecutive", 64'(last_cyc - first_cyc), 64'd5);
        check("f6_nrd", 64'(n_rd), 64'd2);
        check("f6_busy_after", 64'(busy), 64'd0);

        // Partial last word: lanes 5,6 discarded
        q.push_back(mkw(16'h0001));
        q.push_back(mkw(16'h0004));
        @(posedge clk_rd); #1;
        clear_mon();
        start(32'd4);
        wait_done("f4", 1'b0, -1);
        check_samples("f4", 16'h0001, 4);
        check("f4_nrd", 64'(n_rd), 64'd2);
        check("f4_queue_left", 64'(q.size()), 64'd0);

        // Zero-length frame
        clear_mon();
        start(32'd0);
        check("f0_done_t1", 64'(frame_done), 64'd1);
        check("f0_busy_t1", 64'(busy), 64'd0);
        @(posedge clk_rd); #1;
        check("f0_done_t2", 64'(frame_done), 64'd0);
        repeat (3) @(posedge clk_rd);
        #1;
        check("f0_nrd", 64'(n_rd), 64'd0);
        check("f0_nsamp", 64'(got.size()), 64'd0);

        // Backpressure toggling every cycle over nine samples
        q.push_back(mkw(16'h0011));
        q.push_back(mkw(16'h0014));
        q.push_back(mkw(16'h0017));
        @(posedge clk_rd); #1;
        clear_mon();
        start(32'd9);
        wait_done("f9t", 1'b1, -1);
        check_samples("f9t", 16'h0011, 9);
        check("f9t_stall_stable", 64'(stall_bad), 64'd0);
        check("f9t_nrd", 64'(n_rd), 64'd3);

        // Queue empty for five cycles mid-frame
        q.push_back(mkw(16'h0021));
        q.push_back(mkw(16'h0024));
        @(posedge clk_rd); #1;
        clear_mon();
        start(32'd6);
        wait_done("gap", 1'b0, 0);
        check_samples("gap", 16'h0021, 6);
        check("gap_rd_low", 64'(gap_rd), 64'd0);
        check("gap_stalled", 64'(last_cyc - first_cyc > 5), 64'd1);
        check("underflow", 64'(underflow), 64'd0);

        // Stray read data in IDLE is sticky
        inj_valid = 1'b1;
        @(posedge clk_rd); #1;
        inj_valid = 1'b0;
        check("stray_set", 64'(stray_valid), 64'd1);
        q.push_back(mkw(16'h0040));
        @(posedge clk_rd); #1;
        clear_mon();
        start(32'd3);
        wait_done("f3", 1'b0, -1);
        check_samples("f3", 16'h0040, 3);
        check("stray_held", 64'(stray_valid), 64'd1);

        // Asynchronous reset mid-frame
        q.push_back(mkw(16'h0050));
        q.push_back(mkw(16'h0053));
        q.push_back(mkw(16'h0056));
        @(posedge clk_rd); #1;
        clear_mon();
        start(32'd9);
        repeat (3) @(posedge clk_rd);
        #1;
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_valid", 64'(bus.sample_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",   64'(busy),             64'd0);
        check("arst_valid",  64'(bus.sample_valid), 64'd0);
        check("arst_data",   64'(bus.sample_data),  64'd0);
        check("arst_last",   64'(bus.sample_last),  64'd0);
        check("arst_rd",     64'(bus.rd_enable),    64'd0);
        check("arst_stray",  64'(stray_valid),      64'd0);
        q.delete();
        repeat (2) @(posedge clk_rd);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk_rd);
        #1;
        check("post_rst_busy",  64'(busy),        64'd0);
        check("post_rst_stray", 64'(stray_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
